// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an icache and a dcache.
// Grants are combinational with no added latency. A starvation counter gives
// the icache priority after repeated losses. A tag ownership table routes
// returned load data back to the cache that issued the load.
//
// Ports:
//   clock, reset                     single clock, synchronous active-high reset
//   Icache2mem_command/addr          icache request (LOAD only; other values idle)
//   Dcache2mem_command/addr/data     dcache request (LOAD or STORE)
//   mem2proc_response                accept tag for the granted command (0 = none)
//   mem2proc_data/tag                returned load data and its tag (0 = none)
//   proc2mem_command/addr/data       granted request sent to memory
//   Imem2proc_response/data/tag      icache-side view of memory
//   Dmem2proc_response/data/tag      dcache-side view of memory
//   outstanding_count                registered number of valid table entries
//   icache_priority                  registered; 1 = icache wins the next conflict
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  Icache2mem_command,
    input  logic [63:0] Icache2mem_addr,
    input  logic [1:0]  Dcache2mem_command,
    input  logic [63:0] Dcache2mem_addr,
    input  logic [63:0] Dcache2mem_data,
    input  logic [3:0]  mem2proc_response,
    input  logic [63:0] mem2proc_data,
    input  logic [3:0]  mem2proc_tag,
    output logic [1:0]  proc2mem_command,
    output logic [63:0] proc2mem_addr,
    output logic [63:0] proc2mem_data,
    output logic [3:0]  Imem2proc_response,
    output logic [63:0] Imem2proc_data,
    output logic [3:0]  Imem2proc_tag,
    output logic [3:0]  Dmem2proc_response,
    output logic [63:0] Dmem2proc_data,
    output logic [3:0]  Dmem2proc_tag,
    output logic [4:0]  outstanding_count,
    output logic        icache_priority
);

    localparam int unsigned CNT_W     = $clog2(STARVE_LIMIT) + 1;
    localparam int unsigned NUM_TAGS  = 16;
    localparam logic [1:0]  BUS_NONE  = 2'd0;
    localparam logic [1:0]  BUS_LOAD  = 2'd1;
    localparam logic [1:0]  BUS_STORE = 2'd2;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    // Tag table; index 0 means "no tag" and is never made valid.
    logic [NUM_TAGS-1:0] tag_valid, tag_valid_next;
    logic [NUM_TAGS-1:0] tag_owner, tag_owner_next;
    logic [4:0]          count_next;
    logic [CNT_W-1:0]    starve_cnt, starve_next;
    logic                priority_next;

    logic icache_active, dcache_active;
    logic grant_i, grant_d;
    logic accepted, alloc;
    logic ret_hit, ret_owner;

    // Request decode and grant selection.
    always_comb begin
        icache_active = (Icache2mem_command == BUS_LOAD);
        dcache_active = (Dcache2mem_command == BUS_LOAD) ||
                        (Dcache2mem_command == BUS_STORE);
        grant_i       = icache_active && (!dcache_active || icache_priority);
        grant_d       = dcache_active && !grant_i;
        accepted      = (mem2proc_response != 4'd0);
    end

    // Command path to memory and response fan-back.
    always_comb begin
        proc2mem_command   = BUS_NONE;
        proc2mem_addr      = 64'd0;
        proc2mem_data      = 64'd0;
        Imem2proc_response = 4'd0;
        Dmem2proc_response = 4'd0;
        if (grant_i) begin
            proc2mem_command   = BUS_LOAD;
            proc2mem_addr      = Icache2mem_addr;
            Imem2proc_response = mem2proc_response;
        end else if (grant_d) begin
            proc2mem_command   = Dcache2mem_command;
            proc2mem_addr      = Dcache2mem_addr;
            proc2mem_data      = Dcache2mem_data;
            Dmem2proc_response = mem2proc_response;
        end
    end

    // Return routing uses the table as it stood before this cycle's update.
    always_comb begin
        ret_hit        = (mem2proc_tag != 4'd0) && tag_valid[mem2proc_tag];
        ret_owner      = tag_owner[mem2proc_tag];
        Imem2proc_tag  = 4'd0;
        Imem2proc_data = 64'd0;
        Dmem2proc_tag  = 4'd0;
        Dmem2proc_data = 64'd0;
        if (ret_hit && !ret_owner) begin
            Imem2proc_tag  = mem2proc_tag;
            Imem2proc_data = mem2proc_data;
        end else if (ret_hit && ret_owner) begin
            Dmem2proc_tag  = mem2proc_tag;
            Dmem2proc_data = mem2proc_data;
        end
    end

    // Table update: retire first, so a same-tag allocation overrides.
    always_comb begin
        tag_valid_next = tag_valid;
        tag_owner_next = tag_owner;
        alloc          = (proc2mem_command == BUS_LOAD) && accepted;
        if (ret_hit) begin
            tag_valid_next[mem2proc_tag] = 1'b0;
        end
        if (alloc) begin
            tag_valid_next[mem2proc_response] = 1'b1;
            tag_owner_next[mem2proc_response] = grant_d;
        end
        count_next = 5'd0;
        for (int i = 1; i < NUM_TAGS; i++) begin
            count_next = count_next + 5'(tag_valid_next[i]);
        end
    end

    // Starvation tracking; priority rises on the same edge the counter hits the limit.
    always_comb begin
        starve_next   = starve_cnt;
        priority_next = icache_priority;
        if (grant_i && accepted) begin
            starve_next   = '0;
            priority_next = 1'b0;
        end else if (!icache_active) begin
            starve_next = '0;
        end else if (grant_d) begin
            if (starve_cnt < LIMIT) begin
                starve_next = starve_cnt + CNT_W'(1);
            end
            if (starve_next == LIMIT) begin
                priority_next = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_valid         <= '0;
            tag_owner         <= '0;
            outstanding_count <= 5'd0;
            starve_cnt        <= '0;
            icache_priority   <= 1'b0;
        end else begin
            tag_valid         <= tag_valid_next;
            tag_owner         <= tag_owner_next;
            outstanding_count <= count_next;
            starve_cnt        <= starve_next;
            icache_priority   <= priority_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a behavioural model.
module tb_mem_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clock;
    logic        reset;
    logic [1:0]  Icache2mem_command;
    logic [63:0] Icache2mem_addr;
    logic [1:0]  Dcache2mem_command;
    logic [63:0] Dcache2mem_addr;
    logic [63:0] Dcache2mem_data;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  Imem2proc_response;
    logic [63:0] Imem2proc_data;
    logic [3:0]  Imem2proc_tag;
    logic [3:0]  Dmem2proc_response;
    logic [63:0] Dmem2proc_data;
    logic [3:0]  Dmem2proc_tag;
    logic [4:0]  outstanding_count;
    logic        icache_priority;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .Icache2mem_command(Icache2mem_command), .Icache2mem_addr(Icache2mem_addr),
        .Dcache2mem_command(Dcache2mem_command), .Dcache2mem_addr(Dcache2mem_addr),
        .Dcache2mem_data(Dcache2mem_data),
        .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
        .mem2proc_tag(mem2proc_tag),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data),
        .Imem2proc_response(Imem2proc_response), .Imem2proc_data(Imem2proc_data),
        .Imem2proc_tag(Imem2proc_tag),
        .Dmem2proc_response(Dmem2proc_response), .Dmem2proc_data(Dmem2proc_data),
        .Dmem2proc_tag(Dmem2proc_tag),
        .outstanding_count(outstanding_count), .icache_priority(icache_priority)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Model state: who owns each outstanding tag, and the starvation bookkeeping.
    bit owner_valid [16];
    bit owner_is_d  [16];
    int starve_cycles = 0;
    bit model_prio = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int t = 1; t < 16; t++) if (owner_valid[t]) n++;
        return n;
    endfunction

    // One clock cycle: check registered state, apply inputs, check combinational
    // outputs, then advance the model to what the next edge should produce.
    task automatic step(input logic [1:0] ic, input logic [63:0] ia,
                        input logic [1:0] dc, input logic [63:0] da, input logic [63:0] dd,
                        input logic [3:0] resp, input logic [63:0] rdata,
                        input logic [3:0] rtag, input logic rst);
        bit want_i, want_d;
        int winner; // 0 none, 1 icache, 2 dcache
        bit hit, hit_d;
        logic [1:0]  e_cmd;
        logic [63:0] e_addr, e_data;
        @(negedge clock);
        check("outstanding_count", 64'(outstanding_count), 64'(model_count()));
        check("icache_priority", 64'(icache_priority), 64'(model_prio));
        reset = rst;
        Icache2mem_command = ic; Icache2mem_addr = ia;
        Dcache2mem_command = dc; Dcache2mem_addr = da; Dcache2mem_data = dd;
        mem2proc_response = resp; mem2proc_data = rdata; mem2proc_tag = rtag;
        #1;
        want_i = (ic == 2'd1);
        want_d = (dc == 2'd1) || (dc == 2'd2);
        if (want_i && want_d) winner = model_prio ? 1 : 2;
        else if (want_i)      winner = 1;
        else if (want_d)      winner = 2;
        else                  winner = 0;
        e_cmd = 2'd0; e_addr = 64'd0; e_data = 64'd0;
        if (winner == 1) begin e_cmd = 2'd1; e_addr = ia; end
        if (winner == 2) begin e_cmd = dc; e_addr = da; e_data = dd; end
        check("proc2mem_command", 64'(proc2mem_command), 64'(e_cmd));
        check("proc2mem_addr", proc2mem_addr, e_addr);
        check("proc2mem_data", proc2mem_data, e_data);
        check("Imem2proc_response", 64'(Imem2proc_response), (winner == 1) ? 64'(resp) : 64'd0);
        check("Dmem2proc_response", 64'(Dmem2proc_response), (winner == 2) ? 64'(resp) : 64'd0);
        hit   = (rtag != 4'd0) && owner_valid[rtag];
        hit_d = owner_is_d[rtag];
        check("Imem2proc_tag", 64'(Imem2proc_tag), (hit && !hit_d) ? 64'(rtag) : 64'd0);
        check("Imem2proc_data", Imem2proc_data, (hit && !hit_d) ? rdata : 64'd0);
        check("Dmem2proc_tag", 64'(Dmem2proc_tag), (hit && hit_d) ? 64'(rtag) : 64'd0);
        check("Dmem2proc_data", Dmem2proc_data, (hit && hit_d) ? rdata : 64'd0);
        if (rst) begin
            for (int t = 0; t < 16; t++) begin owner_valid[t] = 0; owner_is_d[t] = 0; end
            starve_cycles = 0;
            model_prio = 0;
        end else begin
            if (hit) owner_valid[rtag] = 0;
            if (e_cmd == 2'd1 && resp != 4'd0) begin
                owner_valid[resp] = 1;
                owner_is_d[resp]  = (winner == 2);
            end
            if (winner == 1 && resp != 4'd0) begin
                starve_cycles = 0;
                model_prio = 0;
            end else if (!want_i) begin
                starve_cycles = 0;
            end else if (winner == 2) begin
                if (starve_cycles < int'(LIMIT)) starve_cycles++;
                if (starve_cycles == int'(LIMIT)) model_prio = 1;
            end
        end
        @(posedge clock);
    endtask

    task automatic idle(input logic [3:0] rtag, input logic [63:0] rdata);
        step(2'd0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, rdata, rtag, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        Icache2mem_command = 2'd0; Icache2mem_addr = 64'd0;
        Dcache2mem_command = 2'd0; Dcache2mem_addr = 64'd0; Dcache2mem_data = 64'd0;
        mem2proc_response = 4'd0; mem2proc_data = 64'd0; mem2proc_tag = 4'd0;
        @(posedge clock);
        step(2'd0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 64'd0, 4'd0, 1'b1);

        // Icache load, tag 3 returned two cycles later.
        step(2'd1, 64'h100, 2'd0, 64'd0, 64'd0, 4'd3, 64'd0, 4'd0, 1'b0);
        #1 check("req38_count_after_alloc", 64'(outstanding_count), 64'd1);
        idle(4'd0, 64'd0);
        idle(4'd3, 64'hAA);
        #1 check("req38_count_after_return", 64'(outstanding_count), 64'd0);

        // Conflict: dcache wins at priority 0.
        step(2'd1, 64'h200, 2'd1, 64'h300, 64'd0, 4'd5, 64'd0, 4'd0, 1'b0);
        idle(4'd5, 64'h55);

        // Continuous conflict: icache wins after LIMIT dcache grants.
        for (int i = 0; i < 6; i++) begin
            step(2'd1, 64'h400 + 64'(i), 2'd2, 64'h800 + 64'(i), 64'hD0 + 64'(i),
                 4'(1 + i), 64'd0, 4'd0, 1'b0);
            if (i == 3) #1 check("req40_priority_set", 64'(icache_priority), 64'd1);
            if (i == 4) #1 check("req40_priority_clear", 64'(icache_priority), 64'd0);
        end
        idle(4'd5, 64'h1);

        // Store accepted as tag 7 never allocates.
        step(2'd0, 64'd0, 2'd2, 64'h700, 64'h77, 4'd7, 64'd0, 4'd0, 1'b0);
        idle(4'd7, 64'h99);
        #1 check("req41_count", 64'(outstanding_count), 64'd0);

        // Same-cycle return and reallocation of tag 2.
        step(2'd1, 64'h20, 2'd0, 64'd0, 64'd0, 4'd2, 64'd0, 4'd0, 1'b0);
        step(2'd0, 64'd0, 2'd1, 64'h24, 64'd0, 4'd2, 64'h42, 4'd2, 1'b0);
        #1 check("req42_count", 64'(outstanding_count), 64'd1);
        idle(4'd2, 64'h43);

        // Reset drops outstanding tags.
        step(2'd1, 64'h1000, 2'd0, 64'd0, 64'd0, 4'd4, 64'd0, 4'd0, 1'b0);
        step(2'd0, 64'd0, 2'd1, 64'h1008, 64'd0, 4'd5, 64'd0, 4'd0, 1'b0);
        step(2'd1, 64'h1010, 2'd0, 64'd0, 64'd0, 4'd6, 64'd0, 4'd0, 1'b0);
        step(2'd0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 64'd0, 4'd0, 1'b1);
        idle(4'd4, 64'h4);
        idle(4'd5, 64'h5);
        idle(4'd6, 64'h6);
        #1 check("req43_count", 64'(outstanding_count), 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] r, t;
            r = ($urandom_range(0, 9) < 6) ? 4'($urandom_range(1, 15)) : 4'd0;
            t = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            step(2'($urandom_range(0, 3)), {$urandom, $urandom},
                 2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
                 r, {$urandom, $urandom}, t, ($urandom_range(0, 199) == 0));
        end
        idle(4'd0, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
